// File: rtl/param_cam.sv
// -----------------------------------------------------------------------------
// param_cam - parametrised content-addressable memory
//
// DEPTH entries of DATA_WIDTH bits, each with a valid bit. Supports indexed
// read, indexed write, per-entry invalidate and a fully parallel search with
// lowest-index priority, multi-hit and occupancy reporting. Every result is
// registered one cycle after its request. Read and search observe the array as
// it was before the current edge.
//
// Optional feature macro: CAM_MASK_EN
//   defined   -> search_mask_i exists; a 1 bit means "compare this bit"
//   undefined -> exact match on all DATA_WIDTH bits
//
// Ports
//   clk                 sole clock, rising edge
//   reset_i             synchronous active-high reset (clears valid vector and
//                       all outputs; coincident requests are dropped)
//   read_i/read_index_i                 indexed read request
//   write_i/write_index_i/write_data_i  indexed write, sets entry valid
//   invalidate_i/invalidate_index_i     clears entry valid (wins over write)
//   search_i/search_data_i[/search_mask_i] parallel search request
//   read_valid_o/read_value_o           read result (value 0 unless valid)
//   search_done_o                       pulses one cycle after each search_i
//   search_valid_o/search_index_o/search_multi_o  search result
//   count_o/full_o                      occupancy after the current edge
// Indices >= DEPTH are ignored; such reads return zeros.
// -----------------------------------------------------------------------------
module param_cam #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  read_i,
    input  logic [ADDR_WIDTH-1:0] read_index_i,
    input  logic                  write_i,
    input  logic [ADDR_WIDTH-1:0] write_index_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  invalidate_i,
    input  logic [ADDR_WIDTH-1:0] invalidate_index_i,
    input  logic                  search_i,
    input  logic [DATA_WIDTH-1:0] search_data_i,
`ifdef CAM_MASK_EN
    input  logic [DATA_WIDTH-1:0] search_mask_i,
`endif
    output logic                  read_valid_o,
    output logic [DATA_WIDTH-1:0] read_value_o,
    output logic                  search_done_o,
    output logic                  search_valid_o,
    output logic [ADDR_WIDTH-1:0] search_index_o,
    output logic                  search_multi_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
        return int'(idx) < DEPTH;
    endfunction

    logic [DATA_WIDTH-1:0] mask_p0;
`ifdef CAM_MASK_EN
    assign mask_p0 = search_mask_i;
`else
    assign mask_p0 = '1;
`endif

    // ---- stage p0: combinational lookup against pre-edge array state ----
    logic                  rd_hit_p0;
    logic [DATA_WIDTH-1:0] rd_data_p0;
    logic [DEPTH-1:0]      match_p0;
    logic                  hit_p0;
    logic                  multi_p0;
    logic [ADDR_WIDTH-1:0] hit_idx_p0;
    logic [DEPTH-1:0]      valid_next_p0;
    logic [ADDR_WIDTH:0]   count_next_p0;

    always_comb begin
        rd_hit_p0  = 1'b0;
        rd_data_p0 = '0;
        if (read_i && in_range(read_index_i) && valid[read_index_i]) begin
            rd_hit_p0  = 1'b1;
            rd_data_p0 = mem[read_index_i];
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            match_p0[k] = valid[k] && (((mem[k] ^ search_data_i) & mask_p0) == '0);
    end

    // Scan upward: the first match found is the winner; any later match
    // means at least two entries hit.
    always_comb begin
        hit_p0     = 1'b0;
        multi_p0   = 1'b0;
        hit_idx_p0 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_p0[k]) begin
                if (hit_p0) begin
                    multi_p0 = 1'b1;
                end else begin
                    hit_p0     = 1'b1;
                    hit_idx_p0 = ADDR_WIDTH'(k);
                end
            end
        end
    end

    // Invalidate is applied after write so it wins on a same-index collision.
    always_comb begin
        valid_next_p0 = valid;
        if (write_i && in_range(write_index_i))
            valid_next_p0[write_index_i] = 1'b1;
        if (invalidate_i && in_range(invalidate_index_i))
            valid_next_p0[invalidate_index_i] = 1'b0;
        count_next_p0 = '0;
        for (int k = 0; k < DEPTH; k++)
            count_next_p0 = count_next_p0 + (ADDR_WIDTH+1)'(valid_next_p0[k]);
    end

    // ---- stage p1: registered state and results ----
    always_ff @(posedge clk) begin
        if (!reset_i && write_i && in_range(write_index_i))
            mem[write_index_i] <= write_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            valid          <= '0;
            read_valid_o   <= 1'b0;
            read_value_o   <= '0;
            search_done_o  <= 1'b0;
            search_valid_o <= 1'b0;
            search_index_o <= '0;
            search_multi_o <= 1'b0;
            count_o        <= '0;
            full_o         <= 1'b0;
        end else begin
            valid          <= valid_next_p0;
            read_valid_o   <= rd_hit_p0;
            read_value_o   <= rd_data_p0;
            search_done_o  <= search_i;
            search_valid_o <= search_i && hit_p0;
            search_index_o <= (search_i && hit_p0) ? hit_idx_p0 : '0;
            search_multi_o <= search_i && multi_p0;
            count_o        <= count_next_p0;
            full_o         <= (count_next_p0 == (ADDR_WIDTH+1)'(DEPTH));
        end
    end

endmodule

// File: doc/param_cam.md
# param_cam

Parametrised content-addressable memory: the successor to our fixed 32×32 CAM. DEPTH entries of DATA_WIDTH bits, each with a valid bit. Supports indexed read, indexed write, per-entry invalidate and a fully parallel search with lowest-index priority, multi-hit and occupancy reporting. All results are registered, with one-cycle latency. It sits beside the datapath as a lookup/tag store and is driven by a single controller.

## Interface
- DATA_WIDTH, 32, bits per entry
- ADDR_WIDTH, 5, index width
- DEPTH, 1<<ADDR_WIDTH, entry count; must be ≤ 2**ADDR_WIDTH and ≥ 2
- clk  in  1  sole clock, rising edge
- reset_i  in  1  synchronous, active-high reset
- read_i / read_index_i  in  1 / ADDR_WIDTH  read request and index
- write_i / write_index_i / write_data_i  in  1 / ADDR_WIDTH / DATA_WIDTH  write request, index, data; sets the entry valid
- invalidate_i / invalidate_index_i  in  1 / ADDR_WIDTH  clears the entry valid bit
- search_i / search_data_i  in  1 / DATA_WIDTH  search request and key
- search_mask_i  in  DATA_WIDTH  per-bit care mask, 1 = compare (present only with CAM_MASK_EN)
- read_valid_o  out  1  read hit a valid entry
- read_value_o  out  DATA_WIDTH  entry data when read_valid_o, else 0
- search_done_o  out  1  pulses one cycle after every search_i
- search_valid_o  out  1  at least one valid entry matched
- search_index_o  out  ADDR_WIDTH  lowest matching index, 0 on miss
- search_multi_o  out  1  two or more entries matched
- count_o  out  ADDR_WIDTH+1  number of valid entries
- full_o  out  1  count_o == DEPTH

## Operation
- Storage: DEPTH×DATA_WIDTH data array plus a DEPTH-bit valid vector. Only the valid vector is reset; data contents after reset are don't-care and are never exposed, because invalid reads return 0.
- Read, write, invalidate and search are independent and may all be asserted in the same cycle.
- Read and search see the array state from before the current edge (read-before-write). A same-cycle write is not visible until the next request.
- Write and invalidate to the same index in the same cycle: the invalidate wins and the entry ends invalid. The data array is still written.
- Write to an already-valid entry overwrites its data; count_o is unchanged.
- Invalidate of an already-invalid entry: no effect.
- Index ≥ DEPTH on any port: the request is ignored, and a read or search returns all-zero results with done still pulsing.
- Search match for entry k: valid[k] && ((entry[k] ^ key) & mask) == 0. Without the macro, mask is all ones.
- Priority encoder: lowest matching index wins. search_multi_o = popcount(match) ≥ 2.
- count_o and full_o are registered and reflect the valid vector after the current edge's updates.
- No internal state machine beyond the valid vector and output registers. There is no back-pressure; requests are accepted every cycle.

## Timing
- Reset (reset_i high at an edge): valid vector cleared. All outputs are 0 on the following cycle: read_valid_o, read_value_o, search_done_o, search_valid_o, search_index_o, search_multi_o, count_o, full_o.
- Requests coincident with reset_i are dropped.
- Read: read_i at edge N → read_valid_o/read_value_o valid after edge N, for one cycle. Outputs return to 0 the next cycle if read_i is low.
- Search: search_i at edge N → search_done_o, search_valid_o, search_index_o and search_multi_o valid for one cycle after edge N. All are 0 when search_i was low.
- Write/invalidate at edge N → the entry state changes at N. It is visible to a read or search issued at N+1. count_o and full_o update at N.
- Back-to-back requests every cycle are fully supported at one result per cycle.

## Configuration
- CAM_MASK_EN defined: the search_mask_i port exists and ternary search applies per bit.
- CAM_MASK_EN undefined: the port is absent and search is exact match on all DATA_WIDTH bits. All other behaviour is identical.

## Test plan
- Reset, then write 0xDEAD_BEEF at index 3; the next cycle, read 3 and search 0xDEAD_BEEF → read_valid_o=1, read_value_o=0xDEAD_BEEF, search_valid_o=1, search_index_o=3, search_multi_o=0, count_o=1.
- Write 0x55 at indices 7 and 2, then search 0x55 → search_index_o=2, search_multi_o=1. Invalidate 2, then search → search_index_o=7, search_multi_o=0.
- Write 0xAA to index 4 while reading index 4 in the same cycle → read_valid_o=0 (entry was invalid). A read the next cycle → 0xAA.
- Write and invalidate index 9 in the same cycle → count_o unchanged, and a read of 9 → read_valid_o=0, read_value_o=0.
- Fill all DEPTH entries with distinct values → full_o=1, count_o=DEPTH. Assert reset_i mid-stream → the next cycle, count_o=0, full_o=0, and a search of any value → search_done_o=1, search_valid_o=0.
- With CAM_MASK_EN: store 0x1234_5678, search 0x1234_0000 with mask 0xFFFF_0000 → hit. The same search with mask 0xFFFF_FFFF → miss.
